// File: rtl/stopwatch_set_fsm.sv
// stopwatch_set_fsm: walks the set button through DIGITS edit fields and turns
// the change button into one-hot increment strobes with hold-to-auto-repeat.
module stopwatch_set_fsm #(
   parameter int DIGITS         = 4,
   parameter int REPEAT_DELAY   = 50_000_000,
   parameter int REPEAT_PERIOD  = 10_000_000,
   parameter int TIMEOUT_CYCLES = 500_000_000,
   localparam int FW = $clog2(DIGITS + 1)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              dev_run_i,
   input  logic              set_i,
   input  logic              start_i,
   input  logic              change_i,
   output logic [FW-1:0]     field_o,
   output logic [DIGITS-1:0] inc_o,
   output logic              editing_o
);
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int TW   = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [FW-1:0]     field_q, field_d;
   logic [DIGITS-1:0] inc_q, inc_d;
   logic              editing_q, change_q, armed_q, armed_d;
   logic [RW-1:0]     rep_q, rep_d;
   logic [TW-1:0]     to_q, to_d;
   logic              in_edit, set_acc, rise, tmo, stay;

   always_comb begin
      in_edit = field_q != '0 && field_q <= FW'(DIGITS);
      set_acc = set_i && !start_i;
      rise    = change_i && !change_q;
      tmo     = TIMEOUT_CYCLES != 0 && to_q == TW'(TIMEOUT_CYCLES);
      if (!in_edit)
         field_d = (field_q == '0 && set_acc && !dev_run_i) ? FW'(1) : '0;
      else if (dev_run_i)
         field_d = '0;
      else if (set_acc)
         field_d = field_q == FW'(DIGITS) ? '0 : field_q + 1'b1;
      else
         field_d = tmo ? '0 : field_q;
      stay    = in_edit && field_d == field_q;
      inc_d   = '0;
      armed_d = 1'b0;
      rep_d   = '0;
      // rep_q counts down to the next repeat strobe; any field change leaves it disarmed
      if (stay && rise) begin
         inc_d   = DIGITS'(1) << (field_q - 1'b1);
         armed_d = 1'b1;
         rep_d   = RW'(REPEAT_DELAY - 1);
      end else if (stay && armed_q && change_i) begin
         armed_d = 1'b1;
         if (rep_q == '0) begin
            inc_d = DIGITS'(1) << (field_q - 1'b1);
            rep_d = RW'(REPEAT_PERIOD - 1);
         end else begin
            rep_d = rep_q - 1'b1;
         end
      end
      to_d = (stay && inc_d == '0) ? (to_q == TW'(TIMEOUT_CYCLES) ? to_q : to_q + 1'b1) : '0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         field_q   <= '0;
         inc_q     <= '0;
         editing_q <= 1'b0;
         change_q  <= 1'b0;
         armed_q   <= 1'b0;
         rep_q     <= '0;
         to_q      <= '0;
      end else begin
         field_q   <= field_d;
         inc_q     <= inc_d;
         editing_q <= field_d != '0;
         change_q  <= change_i;
         armed_q   <= armed_d;
         rep_q     <= rep_d;
         to_q      <= to_d;
      end
   end

   assign field_o   = field_q;
   assign inc_o     = inc_q;
   assign editing_o = editing_q;
endmodule

// File: tb/tb_stopwatch_set_fsm.sv
// tb_stopwatch_set_fsm: directed stimulus pushes expected field changes and
// strobes into queues; a monitor pops and compares them as the DUT presents them.
module tb_stopwatch_set_fsm;
   typedef struct {int c; int v;} ev_t;

   logic       clk = 1'b0, rstn = 1'b1;
   logic       dev_run = 1'b0, set = 1'b0, start = 1'b0, change = 1'b0;
   logic [2:0] field_o;
   logic [3:0] inc_o;
   logic       editing_o;
   int         cyc = 0, vec = 0, miss = 0, prev_field = 0;
   bit         mon_en = 1'b0;
   ev_t        sq[$], fq[$];

   stopwatch_set_fsm #(
      .DIGITS(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk_i(clk), .rstn_i(rstn), .dev_run_i(dev_run), .set_i(set),
      .start_i(start), .change_i(change), .field_o(field_o), .inc_o(inc_o),
      .editing_o(editing_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, int got, int exp);
      vec++;
      if (got != exp) begin
         miss++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_field(int c, int f);
      fq.push_back(ev_t'{c, f});
   endtask

   task automatic exp_inc(int c, int v);
      sq.push_back(ev_t'{c, v});
   endtask

   task automatic press_set(int f);
      set = 1'b1;
      exp_field(cyc + 1, f);
      step(1);
      set = 1'b0;
      step(1);
   endtask

   initial begin
      fork
         begin : monitor
            ev_t e;
            forever begin
               @(negedge clk);
               if (mon_en) begin
                  while (sq.size() != 0 && sq[0].c < cyc) begin
                     e = sq.pop_front();
                     chk($sformatf("missing strobe@%0d", e.c), 0, e.v);
                  end
                  if (inc_o != 4'b0) begin
                     if (sq.size() != 0 && sq[0].c == cyc) begin
                        e = sq.pop_front();
                        chk($sformatf("strobe@%0d", e.c), int'(inc_o), e.v);
                     end else
                        chk("stray strobe", int'(inc_o), 0);
                  end
                  while (fq.size() != 0 && fq[0].c < cyc) begin
                     e = fq.pop_front();
                     chk($sformatf("missing field change@%0d", e.c), prev_field, e.v);
                  end
                  if (int'(field_o) != prev_field) begin
                     if (fq.size() != 0 && fq[0].c == cyc) begin
                        e = fq.pop_front();
                        chk($sformatf("field@%0d", e.c), int'(field_o), e.v);
                        chk($sformatf("editing@%0d", e.c), int'(editing_o), int'(e.v != 0));
                     end else
                        chk("stray field change", int'(field_o), prev_field);
                  end
                  prev_field = int'(field_o);
               end
            end
         end
         begin : stimulus
            int n, p, e0;
            #2 rstn = 1'b0;
            #1;
            chk("reset field_o", int'(field_o), 0);
            chk("reset inc_o", int'(inc_o), 0);
            chk("reset editing_o", int'(editing_o), 0);
            step(2);
            rstn = 1'b1;
            step(2);
            prev_field = int'(field_o);
            mon_en = 1'b1;
            // field walk with wrap, then set+start ignored in IDLE and in EDIT
            for (int i = 1; i <= 5; i++) begin
               set = 1'b1;
               exp_field(cyc + 1, i % 5);
               step(1);
               set = 1'b0;
               step(3);
            end
            set = 1'b1; start = 1'b1;
            step(1);
            set = 1'b0; start = 1'b0;
            step(3);
            press_set(1);
            set = 1'b1; start = 1'b1;
            step(1);
            set = 1'b0; start = 1'b0;
            step(3);
            // single press in EDIT_2
            press_set(2);
            n = cyc;
            change = 1'b1;
            exp_inc(n + 1, 4'b0010);
            step(1);
            change = 1'b0;
            step(12);
            // hold in EDIT_4
            press_set(3);
            press_set(4);
            n = cyc;
            change = 1'b1;
            exp_inc(n + 1, 4'b1000);
            exp_inc(n + 9, 4'b1000);
            exp_inc(n + 12, 4'b1000);
            exp_inc(n + 15, 4'b1000);
            exp_inc(n + 18, 4'b1000);
            step(20);
            change = 1'b0;
            step(6);
            // run abort in EDIT_3 at the cycle a repeat strobe is due
            press_set(0);
            press_set(1);
            press_set(2);
            press_set(3);
            n = cyc;
            change = 1'b1;
            exp_inc(n + 1, 4'b0100);
            step(8);
            dev_run = 1'b1;
            exp_field(cyc + 1, 0);
            step(1);
            dev_run = 1'b0;
            step(2);
            press_set(1);
            step(10);
            change = 1'b0;
            step(2);
            p = cyc;
            change = 1'b1;
            exp_inc(p + 1, 4'b0001);
            exp_field(p + 22, 0);
            step(1);
            change = 1'b0;
            step(25);
            // plain timeout, then a strobe at entry+15 postpones it
            e0 = cyc;
            set = 1'b1;
            exp_field(e0 + 1, 1);
            exp_field(e0 + 22, 0);
            step(1);
            set = 1'b0;
            step(25);
            e0 = cyc;
            set = 1'b1;
            exp_field(e0 + 1, 1);
            step(1);
            set = 1'b0;
            step(14);
            change = 1'b1;
            exp_inc(e0 + 16, 4'b0001);
            exp_field(e0 + 37, 0);
            step(1);
            change = 1'b0;
            step(25);
            // async reset while a repeat strobe is on the outputs
            press_set(1);
            n = cyc;
            change = 1'b1;
            exp_inc(n + 1, 4'b0001);
            step(9);
            chk("strobe before reset", int'(inc_o), 1);
            exp_field(cyc, 0);
            rstn = 1'b0;
            change = 1'b0;
            #1;
            chk("async reset field_o", int'(field_o), 0);
            chk("async reset inc_o", int'(inc_o), 0);
            chk("async reset editing_o", int'(editing_o), 0);
            step(2);
            rstn = 1'b1;
            step(10);
            press_set(1);
            step(3);
            chk("strobe queue drained", sq.size(), 0);
            chk("field queue drained", fq.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
            $finish;
         end
      join
   end
endmodule
